// File: rtl/nvdla_cg_hyst_ctrl.sv
// nvdla_cg_hyst_ctrl
// Multi-channel clock-gating controller with idle hysteresis.
// Each channel runs a small OFF/ON/HOLD FSM with a down-counter that keeps the
// gated clock alive for cfg_hold cycles after the request drops. The enable is
// captured on the falling edge of the core clock, so gclk is glitch-free.
//
// Optional build macro: NVDLA_CG_WAKE_CNT_EN
//   When defined, adds a saturating 16-bit OFF->ON wake counter per channel,
//   exported on wake_cnt.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_OFF  | channel idle, clock gated unless an override is active
// ST_ON   | request active, clock running
// ST_HOLD | request gone, clock kept running until the counter expires
module nvdla_cg_hyst_ctrl #(
    parameter int NCH = 4,
    parameter int HW  = 4
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            test_mode,
    input  logic [NCH-1:0]  ch_req,
    input  logic [NCH-1:0]  cfg_force_on,
    input  logic [HW-1:0]   cfg_hold,
    output logic [NCH-1:0]  gclk,
    output logic [NCH-1:0]  ch_on,
    output logic [NCH-1:0]  ch_hold
`ifdef NVDLA_CG_WAKE_CNT_EN
    ,
    output logic [NCH*16-1:0] wake_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e          state_q [NCH];
    state_e          state_d [NCH];
    logic [HW-1:0]   cnt_q   [NCH];
    logic [HW-1:0]   cnt_d   [NCH];
    logic [NCH-1:0]  en_n;
    logic [NCH-1:0]  en_q;

    // Per-channel next-state and hysteresis counter; cfg_hold is sampled only on ON->HOLD.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (ch_req[i]) begin
                        state_d[i] = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!ch_req[i]) begin
                        if (cfg_hold == '0) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i] = ST_HOLD;
                            cnt_d[i]   = cfg_hold;
                        end
                    end
                end
                ST_HOLD: begin
                    if (ch_req[i]) begin
                        state_d[i] = ST_ON;
                    end else if (cnt_q[i] == HW'(1)) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] - HW'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Combinational enable: overrides only touch the enable, never the FSM.
    always_comb begin
        en_n = '0;
        for (int i = 0; i < NCH; i++) begin
            en_n[i] = ch_req[i] | (state_q[i] != ST_OFF) | cfg_force_on[i] | test_mode;
        end
    end

    // Enable capture on the low phase (latch equivalent); reset kills the clock at once.
    always_ff @(negedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            en_q <= '0;
        end else begin
            en_q <= en_n;
        end
    end

    assign gclk  = {NCH{nvdla_core_clk}} & en_q;
    assign ch_on = en_q;

    // HOLD status decode.
    always_comb begin
        ch_hold = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_hold[i] = (state_q[i] == ST_HOLD);
        end
    end

`ifdef NVDLA_CG_WAKE_CNT_EN
    logic [15:0] wake_q [NCH];
    logic [15:0] wake_d [NCH];

    // Wake counter: clear when the channel is fully quiet and cfg_hold is all-ones,
    // else count OFF->ON transitions and saturate.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wake_d[i] = wake_q[i];
            if (!ch_req[i] && !cfg_force_on[i] && !test_mode && (&cfg_hold)) begin
                wake_d[i] = '0;
            end else if ((state_q[i] == ST_OFF) && ch_req[i] && (wake_q[i] != 16'hFFFF)) begin
                wake_d[i] = wake_q[i] + 16'd1;
            end
        end
    end

    // Wake counter registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < NCH; i++) begin
                wake_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                wake_q[i] <= wake_d[i];
            end
        end
    end

    // Pack the per-channel fields onto the output bus.
    always_comb begin
        wake_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            wake_cnt[i*16 +: 16] = wake_q[i];
        end
    end
`endif

endmodule
